// File: rtl/cfg_apb_bridge.sv
// APB write-only slave that turns each host write into one coefficient-RAM write command.
// Optional WAIT timeout is compiled in when CFG_TIMEOUT_EN is defined.
module cfg_apb_bridge #(
   parameter int ADDR_WIDTH     = 7,
   parameter int DATA_WIDTH     = 32,
   parameter int TAPS           = 72,
   parameter int NUM_DENUM      = 5,
   parameter int NUM_CTRL       = 6,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         PSEL,
   input  logic                         PENABLE,
   input  logic                         PWRITE,
   input  logic [ADDR_WIDTH-1:0]        PADDR,
   input  logic signed [DATA_WIDTH-1:0] PWDATA,
   output logic                         PREADY,
   output logic                         PSLVERR,
   output logic                         FRAC_DECI_EN,
   output logic                         IIR_EN,
   output logic                         CTRL_EN,
   output logic                         CIC_R_EN,
   output logic                         WR_EN,
   output logic                         WR_STB,
   output logic [ADDR_WIDTH-1:0]        DATA_ADDR,
   output logic signed [DATA_WIDTH-1:0] DATA_IN,
   input  logic                         RAM_READY,
   output logic [7:0]                   WR_CNT
);

   localparam int CTRL_BASE = TAPS + NUM_DENUM;
   localparam int CIC_ADDR  = TAPS + NUM_DENUM + NUM_CTRL;

   if (CIC_ADDR + 1 > 2 ** ADDR_WIDTH) begin : g_map_check
      $error("cfg_apb_bridge: address map does not fit in ADDR_WIDTH");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
      $error("cfg_apb_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WAIT,
      S_RESP,
      S_ERR
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   // One-hot region of the held address: {cic, ctrl, iir, frac}; zero means reject.
   logic [3:0]              region_q, region_d;
   logic                    setup;
   logic                    active;

   assign setup = (state_q == S_IDLE) && PSEL && !PENABLE;

   // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
   always_comb begin
      region_d = 4'b0000;
      if (PWRITE) begin
         if (int'(PADDR) < TAPS)           region_d = 4'b0001;
         else if (int'(PADDR) < CTRL_BASE) region_d = 4'b0010;
         else if (int'(PADDR) < CIC_ADDR)  region_d = 4'b0100;
         else if (int'(PADDR) == CIC_ADDR) region_d = 4'b1000;
      end
   end

`ifdef CFG_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            to_hit;

   assign to_hit = !RAM_READY && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else if (state_q != S_WAIT) begin
         to_cnt_q <= '0;
      end else if (!RAM_READY) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (setup) state_d = (region_d != 4'b0000) ? S_CMD : S_ERR;
         end
         S_CMD: state_d = PSEL ? S_WAIT : S_IDLE;
         S_WAIT: begin
            if (!PSEL)          state_d = S_IDLE;
            else if (RAM_READY) state_d = S_RESP;
`ifdef CFG_TIMEOUT_EN
            else if (to_hit)    state_d = S_ERR;
`endif
         end
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         data_q   <= '0;
         region_q <= '0;
         WR_CNT   <= '0;
      end else begin
         state_q <= state_d;
         if (setup) begin
            addr_q   <= PADDR;
            data_q   <= PWDATA;
            region_q <= region_d;
         end
         if (state_q == S_WAIT && state_d == S_RESP) WR_CNT <= WR_CNT + 8'd1;
      end
   end

   // Outputs depend only on registers, never on the P* inputs.
   assign active       = (state_q == S_CMD) || (state_q == S_WAIT);
   assign FRAC_DECI_EN = active && region_q[0];
   assign IIR_EN       = active && region_q[1];
   assign CTRL_EN      = active && region_q[2];
   assign CIC_R_EN     = active && region_q[3];
   assign WR_EN        = active;
   assign WR_STB       = (state_q == S_CMD);
   assign PREADY       = (state_q == S_RESP) || (state_q == S_ERR);
   assign PSLVERR      = (state_q == S_ERR);
   assign DATA_ADDR    = addr_q;
   assign DATA_IN      = data_q;

endmodule

// File: doc/cfg_apb_bridge.md
# cfg_apb_bridge

APB-style write-only slave that takes coefficient/control writes from the host bus and turns each one into a single write command for the coefficient RAM. It decodes the flat address into the four region enables (fractional decimator taps, IIR coefficients, control words, CIC ratio). It passes the flat address and data unchanged, waits for the RAM's ready, and completes the APB transfer with `PREADY`/`PSLVERR`. It sits directly upstream of the coefficient RAM in the configuration path.

## Interface
Parameters:
- `ADDR_WIDTH`, 7: width of `PADDR` and `DATA_ADDR`.
- `DATA_WIDTH`, 32: width of write data.
- `TAPS`, 72: size of the decimator region.
- `NUM_DENUM`, 5: size of the IIR region.
- `NUM_CTRL`, 6: size of the control region.
- `TIMEOUT_CYCLES`, 16: number of WAIT cycles before a timeout. Used only with `CFG_TIMEOUT_EN`.
- Elaboration requirement: `TAPS+NUM_DENUM+NUM_CTRL+1 <= 2**ADDR_WIDTH`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `PSEL` in 1: APB select.
- `PENABLE` in 1: APB enable.
- `PWRITE` in 1: APB direction.
- `PADDR` in `ADDR_WIDTH`: flat address.
- `PWDATA` in `DATA_WIDTH` (signed): write data.
- `PREADY` out 1: transfer complete.
- `PSLVERR` out 1: error; valid only while `PREADY`=1.
- `FRAC_DECI_EN`, `IIR_EN`, `CTRL_EN`, `CIC_R_EN` out 1 each: region enables. One-hot or all zero.
- `WR_EN` out 1: drives the RAM's write qualifier.
- `WR_STB` out 1: drives the RAM's enable strobe.
- `DATA_ADDR` out `ADDR_WIDTH`: flat address to the RAM.
- `DATA_IN` out `DATA_WIDTH` (signed): data to the RAM.
- `RAM_READY` in 1: ready from the RAM.
- `WR_CNT` out 8: count of successful writes.

## Operation
Address map, flat address `A`:
- `A < TAPS` → `FRAC_DECI_EN`.
- `A < TAPS+NUM_DENUM` → `IIR_EN`.
- `A < TAPS+NUM_DENUM+NUM_CTRL` → `CTRL_EN`.
- `A == TAPS+NUM_DENUM+NUM_CTRL` → `CIC_R_EN`.
- Any higher address is invalid.

FSM states and transitions:
- IDLE: on `PSEL & !PENABLE`, latch `PADDR`/`PWDATA`/`PWRITE` into hold registers and decode them.
  - Invalid address or `PWRITE`=0 → ERR.
  - Otherwise → CMD.
- CMD (1 cycle): decoded enable=1, `WR_EN`=1, `WR_STB`=1. Next state WAIT.
- WAIT: enable and `WR_EN` held at 1, `WR_STB`=0.
  - `RAM_READY`=1 → RESP.
- RESP (1 cycle): `PREADY`=1, `PSLVERR`=0, `WR_CNT`+1 (wraps 255→0). Next state IDLE.
- ERR (1 cycle): `PREADY`=1, `PSLVERR`=1, no enable asserted. Next state IDLE.

Other rules:
- `DATA_ADDR`/`DATA_IN` come from the hold registers and keep the last latched value between transfers. Downstream valid flags decode `DATA_ADDR`, so it must not glitch.
- `PSEL` deasserted in CMD or WAIT: abort to IDLE, no `PREADY`, `WR_CNT` unchanged. A RAM write issued in CMD stands.
- Setup while not in IDLE: ignored. The master must not issue one.

## Timing
- Reset values: `PREADY`=0, `PSLVERR`=0, all enables=0, `WR_EN`=0, `WR_STB`=0, `DATA_ADDR`=0, `DATA_IN`=0, `WR_CNT`=0, state=IDLE.
- Reset asserted mid-transfer: returns to IDLE on the next edge with no response.
- Valid write, with the setup cycle as T0:
  - T1 = CMD.
  - T2 = WAIT; `RAM_READY` rises here because the RAM registers ready off the CMD edge.
  - T3 = `PREADY`.
  - Minimum latency is 3 cycles after setup; each extra cycle of `RAM_READY`=0 adds one cycle.
- Error: `PREADY`+`PSLVERR` at T1.
- All outputs are decoded from registered state and hold registers; no combinational path from `P*` inputs to outputs.

## Configuration
- `CFG_TIMEOUT_EN` defined:
  - WAIT counts cycles with `RAM_READY`=0.
  - When the count reaches `TIMEOUT_CYCLES`, go to ERR: enables drop and `PSLVERR`=1 in the following cycle.
  - The counter clears on entry to WAIT.
- Not defined: WAIT waits indefinitely and the counter logic is absent.

## Test plan
- Write `PADDR`=0, `PWDATA`=0x12345678, `RAM_READY` model = one-cycle-delayed `WR_EN` → `FRAC_DECI_EN` high T1–T2, `WR_STB` only at T1, `DATA_ADDR`=0, `PREADY`=1 at T3 with `PSLVERR`=0, `WR_CNT`=1.
- Write `PADDR`=72, then 77, then 83 → `IIR_EN`, `CTRL_EN`, `CIC_R_EN` respectively, each one-hot; `DATA_ADDR` holds 83 after the last write; `WR_CNT`=3.
- Write `PADDR`=84, and separately a read at `PADDR`=5 → `PREADY`=`PSLVERR`=1 at T1, no enable or `WR_STB` asserted, `WR_CNT` unchanged.
- `RAM_READY` tied 0, `CFG_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16 → `PSLVERR` 16 cycles after WAIT entry; without the macro, no `PREADY` within 100 cycles.
- `rst`=1 during WAIT, or `PSEL` dropped in WAIT → IDLE next cycle, all outputs at the values given, no `PREADY`.
- 256 back-to-back valid writes → `WR_CNT` wraps to 0.
